// File: rtl/tone_rx.sv
// Tone period receiver: synchronises a square-wave input, measures the cycle count
// between rising edges and declares lock once the period has stayed stable.
module tone_rx #(
  parameter int PER_W    = 16,
  parameter int LOCK_CNT = 8,
  parameter int TOL      = 1,
  parameter int TIMEOUT  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_in,
  output logic [PER_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, TRACK = 2'd2, LOCKED = 2'd3} state_t;

  state_t           state, state_next;
  logic             sync1, sync2, sync_prev, rise;
  logic [PER_W-1:0] count;
  logic [CW-1:0]    match_cnt, match_next;
  logic [PER_W:0]   diff;
  logic             match, load, timeout;

  // Edge detect is registered once more so a period is reported on the
  // third clock after the input is first sampled high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
      rise      <= 1'b0;
    end else begin
      sync1     <= rx_in;
      sync2     <= sync1;
      sync_prev <= sync2;
      rise      <= sync2 & ~sync_prev;
    end
  end

  // One extra bit keeps the absolute difference free of overflow.
  always_comb begin
    if ({1'b0, count} >= {1'b0, period})
      diff = {1'b0, count} - {1'b0, period};
    else
      diff = {1'b0, period} - {1'b0, count};
  end

  assign match   = (diff <= (PER_W+1)'(TOL));
  assign timeout = (state != IDLE) && (count == PER_W'(TIMEOUT));

  always_comb begin
    state_next = state;
    match_next = match_cnt;
    load       = 1'b0;
    if (rise) begin
      case (state)
        IDLE:  state_next = ARMED;
        ARMED: begin
          load       = 1'b1;
          match_next = '0;
          state_next = TRACK;
        end
        TRACK: begin
          load = 1'b1;
          if (match) begin
            match_next = match_cnt + 1'b1;
            if (match_next == CW'(LOCK_CNT))
              state_next = LOCKED;
          end else begin
            match_next = '0;
          end
        end
        LOCKED: begin
          load = 1'b1;
          if (!match) begin
            match_next = '0;
            state_next = TRACK;
          end
        end
        default: state_next = IDLE;
      endcase
    end else if (timeout) begin
      state_next = IDLE;
      match_next = '0;
    end
  end

  // The counter restarts at 1 on each edge so that it equals the period at the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      match_cnt    <= '0;
      count        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
    end else begin
      state        <= state_next;
      match_cnt    <= match_next;
      period_valid <= load;
      locked       <= (state_next == LOCKED);
      if (load)
        period <= count;
      if (rise)
        count <= PER_W'(1);
      else if (state_next == IDLE)
        count <= '0;
      else
        count <= count + 1'b1;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_tone_rx.sv
// Randomised and directed bench for tone_rx, checked against a timestamp-based
// model of edge arrivals, period matching and lock/timeout rules.
module tb_tone_rx;

  localparam int PER_W    = 16;
  localparam int LOCK_CNT = 8;
  localparam int TOL      = 1;
  localparam int TIMEOUT  = 1024;
  localparam int S_IDLE = 0, S_ARMED = 1, S_TRACK = 2, S_LOCKED = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             rx_in;
  logic [PER_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic [1:0]       state_dbg;

  tone_rx #(.PER_W(PER_W), .LOCK_CNT(LOCK_CNT), .TOL(TOL), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .period(period),
    .period_valid(period_valid), .locked(locked), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: sample history, timestamps of processed edges, run of matches.
  logic [4:0] hist;
  int cyc, last_t, m_state, run, exp_period, exp_pv, exp_locked;

  // Observation bookkeeping.
  int pulses, lock_at, last_pv_cyc, fall_cyc, seen_1024;
  logic pv_prev, locked_prev;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    hist = '0; last_t = 0; m_state = S_IDLE; run = 0;
    exp_period = 0; exp_pv = 0; exp_locked = 0;
    pulses = 0; lock_at = -1; pv_prev = 1'b0; locked_prev = 1'b0;
  endtask

  task automatic model_update();
    int gap, d;
    bit edge_now;
    hist = {hist[3:0], rx_in};
    edge_now = hist[3] & ~hist[4];
    gap = cyc - last_t;
    exp_pv = 0;
    if (edge_now) begin
      if (m_state == S_IDLE) begin
        m_state = S_ARMED;
      end else begin
        d = (gap > exp_period) ? gap - exp_period : exp_period - gap;
        exp_pv = 1;
        if (m_state == S_ARMED) begin
          run = 0; m_state = S_TRACK;
        end else if (d > TOL) begin
          run = 0; m_state = S_TRACK;
        end else if (m_state == S_TRACK) begin
          run++;
          if (run == LOCK_CNT) m_state = S_LOCKED;
        end
        exp_period = gap;
      end
      last_t = cyc;
    end else if (m_state != S_IDLE && gap == TIMEOUT) begin
      m_state = S_IDLE; run = 0;
    end
    exp_locked = (m_state == S_LOCKED);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_update();
    @(negedge clk);
    checkOutput("period_valid", period_valid, exp_pv);
    checkOutput("locked", locked, exp_locked);
    checkOutput("state_dbg", state_dbg, m_state);
    checkOutput("period", period, exp_period);
    checkOutput("pv_adjacent", period_valid & pv_prev, 0);
    if (period_valid) begin
      pulses++;
      last_pv_cyc = cyc;
      if (period == 16'(TIMEOUT) && state_dbg != 2'd0) seen_1024 = 1;
    end
    if (locked && !locked_prev && lock_at < 0) lock_at = pulses;
    if (!locked && locked_prev) fall_cyc = cyc;
    pv_prev = period_valid;
    locked_prev = locked;
  endtask

  task automatic applyStimulus(input int high, input int low);
    rx_in = 1'b1;
    repeat (high) step();
    rx_in = 1'b0;
    repeat (low) step();
  endtask

  task automatic tone(input int per, input int n);
    repeat (n) applyStimulus(per / 2, per - per / 2);
  endtask

  task automatic reset_pulse();
    #2 rst = 1'b1;
    #0.5;
    checkOutput("async_rst_period", period, 0);
    checkOutput("async_rst_pv", period_valid, 0);
    checkOutput("async_rst_locked", locked, 0);
    checkOutput("async_rst_state", state_dbg, 0);
    #0.5 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int per, high;
    rst = 1'b1; rx_in = 1'b0; cyc = 0; seen_1024 = 0; last_pv_cyc = 0; fall_cyc = 0;
    model_reset();
    repeat (3) @(negedge clk);
    checkOutput("reset_period", period, 0);
    checkOutput("reset_pv", period_valid, 0);
    checkOutput("reset_locked", locked, 0);
    checkOutput("reset_state", state_dbg, 0);
    rst = 1'b0;
    repeat (4) step();

    $display("[TB] steady 16-cycle tone");
    tone(16, 12);
    checkOutput("lock_pulse_index", lock_at, 9);

    $display("[TB] tolerance and mismatch while locked");
    applyStimulus(8, 9); applyStimulus(8, 8); applyStimulus(8, 9); applyStimulus(8, 8);
    checkOutput("locked_within_tol", locked, 1);
    applyStimulus(10, 10);
    applyStimulus(8, 8);
    checkOutput("unlocked_after_20", locked, 0);
    tone(16, 10);
    checkOutput("relocked", locked, 1);

    $display("[TB] timeout while locked");
    rx_in = 1'b0;
    repeat (1100) step();
    checkOutput("timeout_delay", fall_cyc - last_pv_cyc, TIMEOUT);
    checkOutput("idle_after_timeout", state_dbg, 0);

    $display("[TB] edge exactly at timeout");
    tone(16, 3);
    applyStimulus(8, TIMEOUT - 8);
    applyStimulus(8, 8);
    checkOutput("edge_at_timeout", seen_1024, 1);

    $display("[TB] async reset while locked");
    tone(16, 12);
    checkOutput("locked_before_rst", locked, 1);
    rx_in = 1'b1;
    reset_pulse();
    applyStimulus(3, 8);
    tone(16, 12);
    checkOutput("lock_after_rst", lock_at, 10);

    $display("[TB] glitch while tracking");
    rx_in = 1'b0;
    repeat (1100) step();
    tone(16, 5);
    applyStimulus(8, 2); applyStimulus(1, 5); applyStimulus(8, 8); applyStimulus(8, 8);
    checkOutput("glitch_unlocked", locked, 0);

    $display("[TB] random tone");
    for (int i = 0; i < 300; i++) begin
      per = ($urandom_range(0, 7) == 0) ? $urandom_range(3, 40) : $urandom_range(15, 17);
      high = $urandom_range(1, per - 1);
      applyStimulus(high, per - high);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
